// File: rtl/data_memory_responder.sv
// CPU-side data RAM with registered, write-first reads, plus a result streamer
// that walks a fixed address window out over valid/ready once the CPU finishes.
module data_memory_responder #(
  parameter int DEPTH       = 1024,
  parameter int DUMP_BASE   = 0,
  parameter int DUMP_LENGTH = 256
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic [15:0] CPU_ADDRESS,
  input  logic [7:0]  CPU_DATA,
  input  logic        CPU_WRITE_EN,
  input  logic        PROCESS_FINISHED,
  output logic [7:0]  DATA_FROM_RAM,
  input  logic        DUMP_READY,
  output logic        DUMP_VALID,
  output logic [7:0]  DUMP_DATA,
  output logic [15:0] DUMP_ADDRESS,
  output logic        DUMP_DONE,
  output logic        OUT_OF_RANGE
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = (DUMP_LENGTH > 1) ? $clog2(DUMP_LENGTH + 1) : 1;
  localparam logic [16:0]   DEPTH_L   = 17'(DEPTH);
  localparam logic [AW-1:0] BASE_A    = AW'(DUMP_BASE);
  localparam logic [15:0]   BASE_16   = 16'(DUMP_BASE);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DUMP_LENGTH - 1);

  if (DUMP_BASE + DUMP_LENGTH > DEPTH) begin : g_bad_window
    $error("dump window exceeds memory depth");
  end

  typedef enum logic [1:0] {RUN, FETCH, PRESENT, DONE} state_t;

  logic [7:0]    mem [DEPTH];
  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    read_q, read_d;
  logic          valid_q, valid_d;
  logic [7:0]    dump_data_q, dump_data_d;
  logic [15:0]   dump_addr_q, dump_addr_d;
  logic          done_q, done_d;
  logic          oor_q, oor_d;

  logic          cpu_in_range;
  logic [AW-1:0] cpu_index;
  logic [AW-1:0] dump_index;
  logic          wr_fire;

  assign cpu_in_range = ({1'b0, CPU_ADDRESS} < DEPTH_L);
  assign cpu_index    = CPU_ADDRESS[AW-1:0];
  assign dump_index   = BASE_A + AW'(idx_q);
  assign wr_fire      = (state_q == RUN) && CPU_WRITE_EN && cpu_in_range;

  // Memory has no reset so contents survive a mid-dump reset.
  always_ff @(posedge CLOCK) begin
    if (wr_fire) mem[cpu_index] <= CPU_DATA;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    dump_data_d = dump_data_q;
    dump_addr_d = dump_addr_q;
    done_d      = done_q;
    oor_d       = oor_q | ~cpu_in_range;

    if (!cpu_in_range)  read_d = 8'h00;
    else if (wr_fire)   read_d = CPU_DATA;
    else                read_d = mem[cpu_index];

    case (state_q)
      RUN: begin
        if (PROCESS_FINISHED) state_d = FETCH;
      end
      FETCH: begin
        dump_data_d = mem[dump_index];
        dump_addr_d = BASE_16 + 16'(idx_q);
        valid_d     = 1'b1;
        state_d     = PRESENT;
      end
      PRESENT: begin
        if (DUMP_READY) begin
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= RUN;
      idx_q       <= '0;
      read_q      <= '0;
      valid_q     <= 1'b0;
      dump_data_q <= '0;
      dump_addr_q <= '0;
      done_q      <= 1'b0;
      oor_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      read_q      <= read_d;
      valid_q     <= valid_d;
      dump_data_q <= dump_data_d;
      dump_addr_q <= dump_addr_d;
      done_q      <= done_d;
      oor_q       <= oor_d;
    end
  end

  assign DATA_FROM_RAM = read_q;
  assign DUMP_VALID    = valid_q;
  assign DUMP_DATA     = dump_data_q;
  assign DUMP_ADDRESS  = dump_addr_q;
  assign DUMP_DONE     = done_q;
  assign OUT_OF_RANGE  = oor_q;

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Memory-side responder for the CPU data port. It accepts writes on CPU_ADDRESS/CPU_DATA/CPU_WRITE_EN and returns read data on DATA_FROM_RAM.
- When the CPU raises PROCESS_FINISHED, it streams a fixed result window of memory out to a host over a valid/ready port.
- It sits beside the CPU in the top level, in place of a bare RAM.

Parameters:
- DEPTH, 1024, number of 8-bit words stored; valid addresses are 0..DEPTH-1.
- DUMP_BASE, 0, first address streamed out after completion.
- DUMP_LENGTH, 256, number of words streamed out. DUMP_BASE+DUMP_LENGTH <= DEPTH is an elaboration-time check.

Ports:
- CLOCK  input  1  block clock.
- RESET_N  input  1  reset, asynchronous, active-low.
- CPU_ADDRESS  input  16  CPU data address.
- CPU_DATA  input  8  CPU write data.
- CPU_WRITE_EN  input  1  CPU write strobe.
- PROCESS_FINISHED  input  1  CPU completion flag, level.
- DATA_FROM_RAM  output  8  registered read data to CPU.
- DUMP_READY  input  1  host accepts the current word.
- DUMP_VALID  output  1  DUMP_DATA/DUMP_ADDRESS valid.
- DUMP_DATA  output  8  streamed word.
- DUMP_ADDRESS  output  16  address of streamed word.
- DUMP_DONE  output  1  all DUMP_LENGTH words transferred.
- OUT_OF_RANGE  output  1  sticky: CPU accessed an address >= DEPTH.

Behaviour:
- Reset: while RESET_N=0, all outputs are 0, the state is RUN and the dump index is 0. Memory contents are not cleared. RESET_N deasserting takes effect on the next CLOCK edge.
- CPU write, RUN state only: on a CLOCK rising edge with CPU_WRITE_EN=1 and CPU_ADDRESS < DEPTH, mem[CPU_ADDRESS] <= CPU_DATA.
- CPU read, all states: every edge, DATA_FROM_RAM <= mem[CPU_ADDRESS] (one-cycle latency). Read and write at the same address on the same edge returns the new data (write-first).
- Out of range: CPU_ADDRESS >= DEPTH with CPU_WRITE_EN=1 drops the write. A read at such an address returns 0x00. OUT_OF_RANGE is set on the first such edge and stays set until reset; a write to an out-of-range address also sets it.
- States are RUN, FETCH, PRESENT, DONE.
  - RUN: normal CPU service. If PROCESS_FINISHED=1 at an edge, go to FETCH. A CPU write on that same edge still completes.
  - FETCH: DUMP_DATA <= mem[DUMP_BASE+idx] and DUMP_ADDRESS <= DUMP_BASE+idx; DUMP_VALID <= 1; go to PRESENT.
  - PRESENT: DUMP_VALID=1. DUMP_DATA and DUMP_ADDRESS hold stable while DUMP_READY=0.
    - On an edge with DUMP_READY=1, DUMP_VALID <= 0.
    - If idx = DUMP_LENGTH-1, go to DONE. Otherwise idx <= idx+1 and go to FETCH.
  - DONE: DUMP_DONE=1 and DUMP_VALID=0. Remains here until reset.
- Transfer throughput is 1 word per 2 CLOCK cycles when DUMP_READY is held high.
- In FETCH, PRESENT and DONE, CPU writes are ignored; reads still respond.
- PROCESS_FINISHED changes after leaving RUN are ignored.
- DUMP_READY outside PRESENT is ignored.
- The index is wide enough for DUMP_LENGTH and does not wrap. DUMP_ADDRESS never exceeds DUMP_BASE+DUMP_LENGTH-1.
- Reset asserted mid-dump: immediate return to RUN with idx=0 and DUMP_VALID=0. Memory is preserved, so a fresh PROCESS_FINISHED restarts the stream from DUMP_BASE.

Test Plan:
- Reset with RESET_N=0 during random CLOCK activity -> all outputs 0, state RUN.
- Write 0xA5 to address 3, then read address 3 -> DATA_FROM_RAM=0xA5 one cycle after the read address is applied. Write 0x3C to address 3 and read it on the same edge -> 0x3C.
- Write 0x77 to address 1024 (DEPTH=1024) -> OUT_OF_RANGE=1 from the next edge. Reading address 1024 -> 0x00. Address 0 is unchanged. The flag stays 1 through later legal accesses.
- Fill addresses 0..255 with the value (addr XOR 0x5A), raise PROCESS_FINISHED, hold DUMP_READY=1:
  - exactly 256 transfers, words arriving every 2 cycles;
  - word k has DATA = k^0x5A and ADDRESS = k;
  - DUMP_DONE=1 after the last transfer.
- Backpressure: hold DUMP_READY=0 for 5 cycles in PRESENT -> DUMP_VALID, DUMP_DATA and DUMP_ADDRESS are stable. Raising READY transfers exactly one word. A CPU write to address 0 during the dump leaves mem[0] unchanged.
- Pulse RESET_N low while word 10 is presented -> DUMP_VALID=0 and DUMP_DONE=0. Raising PROCESS_FINISHED again restarts at DUMP_ADDRESS=0 with the original data.
